// File: rtl/conn_topk.sv
// conn_topk: keeps the K smallest-distance connections of a stream in a
// sorted table, then drains them in ascending distance order.
// Optional feature macro: CONN_TOPK_DROP_CNT_EN adds a saturating drop_cnt
// output counting connections discarded while collecting.

package aoc_types_pkg;
  typedef struct packed {
    logic [37:0] distance;
    logic [9:0]  pointa;
    logic [9:0]  pointb;
  } conn_t;
endpackage

module conn_topk
  import aoc_types_pkg::*;
#(
  parameter int K      = 1000,
  parameter int PTR_W  = 10,
  parameter int DIST_W = 38
) (
  input  logic  clk,
  input  logic  rst_n,
  input  conn_t conn,
  input  logic  conn_vld,
  input  logic  in_last,
  output conn_t out_conn,
  output logic  out_vld,
  input  logic  out_rdy,
  output logic  done,
  output logic  overrun
`ifdef CONN_TOPK_DROP_CNT_EN
  ,
  output logic [31:0] drop_cnt
`endif
);

  localparam int CNT_W = $clog2(K + 1);
  localparam logic [CNT_W-1:0] K_CNT = CNT_W'(K);

  // The widths describe the packed conn_t; a mismatch is a build error.
  if (DIST_W + 2 * PTR_W != $bits(conn_t)) begin : g_bad_width
    $error("conn_topk: PTR_W/DIST_W do not match conn_t");
  end

  typedef enum logic [1:0] {COLLECT, DRAIN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  conn_t            tbl [K];
  logic [CNT_W-1:0] count;
  logic [K-1:0]     at_or_after;
  logic             accept;
  logic             full;
  logic             do_insert;
  logic             do_pop;

  // Slot i lies at or after the insertion point when it is empty or holds a
  // strictly greater distance; the table is sorted, so this mask is a suffix
  // and its first set bit is the insertion slot (ties keep arrival order).
  always_comb begin
    accept      = (state == COLLECT) && conn_vld;
    full        = (count == K_CNT);
    at_or_after = '0;
    for (int i = 0; i < K; i++) begin
      at_or_after[i] = (CNT_W'(i) >= count) || (tbl[i].distance > conn.distance);
    end
    // No slot in the mask means a full table whose tail is <= the new one.
    do_insert = accept && at_or_after[K-1];
    do_pop    = (state == DRAIN) && (count != '0) && out_rdy;
  end

  // Table update: shift-insert while collecting, shift-to-head on each pop.
  always_ff @(posedge clk) begin
    if (do_insert) begin
      if (at_or_after[0]) tbl[0] <= conn;
      for (int i = 1; i < K; i++) begin
        if (at_or_after[i]) tbl[i] <= at_or_after[i-1] ? tbl[i-1] : conn;
      end
    end else if (do_pop) begin
      for (int i = 0; i < K - 1; i++) begin
        tbl[i] <= tbl[i+1];
      end
    end
  end

  // Occupancy: grows until full (eviction keeps it at K), shrinks per pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (do_insert && !full) begin
      count <= count + 1'b1;
    end else if (do_pop) begin
      count <= count - 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    out_vld   = 1'b0;
    done      = 1'b0;
    out_conn  = tbl[0];
    case (state)
      COLLECT: if (in_last) state_nxt = DRAIN;
      DRAIN: begin
        out_vld = (count != '0);
        if (count == '0) state_nxt = DONE;
      end
      DONE:    done = 1'b1;
      default: state_nxt = COLLECT;
    endcase
  end

  // Sticky flag for input arriving after the stream has closed.
  always_ff @(posedge clk) begin
    if (!rst_n)                            overrun <= 1'b0;
    else if (conn_vld && state != COLLECT) overrun <= 1'b1;
  end

`ifdef CONN_TOPK_DROP_CNT_EN
  // Any accepted conn on a full table discards one entry: itself or the tail.
  always_ff @(posedge clk) begin
    if (!rst_n)                                        drop_cnt <= '0;
    else if (accept && full && drop_cnt != 32'hFFFF_FFFF) drop_cnt <= drop_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_conn_topk.sv
// Bench for conn_topk with K=4: directed scenarios plus a randomized stream,
// all checked against a queue-based sorted top-K model.
module tb_conn_topk;
  import aoc_types_pkg::*;

  localparam int K = 4;

  logic  clk = 1'b0;
  logic  rst_n;
  conn_t conn;
  logic  conn_vld;
  logic  in_last;
  conn_t out_conn;
  logic  out_vld;
  logic  out_rdy;
  logic  done;
  logic  overrun;
`ifdef CONN_TOPK_DROP_CNT_EN
  logic [31:0] drop_cnt;
`endif

  conn_topk #(.K(K), .PTR_W(10), .DIST_W(38)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .conn     (conn),
    .conn_vld (conn_vld),
    .in_last  (in_last),
    .out_conn (out_conn),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .done     (done),
    .overrun  (overrun)
`ifdef CONN_TOPK_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int    passed = 0;
  int    total  = 0;
  int    fails  = 0;
  conn_t model[$];
  int    drop_model = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic conn_t mk(input logic [37:0] d, input logic [9:0] a, input logic [9:0] b);
    conn_t c;
    c.distance = d;
    c.pointa   = a;
    c.pointb   = b;
    return c;
  endfunction

  // Sorted top-K reference: insert after all entries with distance <= new.
  function automatic void model_insert(input conn_t c);
    int pos = model.size();
    for (int i = 0; i < model.size(); i++) begin
      if (model[i].distance > c.distance) begin
        pos = i;
        break;
      end
    end
    if (model.size() == K) begin
      drop_model++;
      if (pos == K) return;
      model.insert(pos, c);
      void'(model.pop_back());
    end else begin
      model.insert(pos, c);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    conn_vld = 1'b0;
    in_last  = 1'b0;
    out_rdy  = 1'b0;
    conn     = '0;
    tick();
    tick();
    rst_n = 1'b1;
    model.delete();
    drop_model = 0;
  endtask

  task automatic send(input conn_t c, input bit last);
    conn     = c;
    conn_vld = 1'b1;
    in_last  = last;
    tick();
    conn_vld = 1'b0;
    in_last  = 1'b0;
    model_insert(c);
  endtask

  task automatic pulse_last();
    in_last = 1'b1;
    tick();
    in_last = 1'b0;
  endtask

  // Drain against the model. mode 0: always ready, 1: toggle starting
  // stalled, 2: random. inject drives a stray conn on cycle 1. A positive
  // stop_after returns right after that many pops.
  task automatic drain(input string tag, input int mode, input bit inject, input int stop_after);
    conn_t prev = '0;
    bit    stalled = 1'b0;
    bit    rdy;
    int    popped = 0;
    int    cyc = 0;
    int    w = 0;
    while (model.size() > 0 && cyc < 200) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      out_rdy = rdy;
      if (inject && cyc == 1) begin
        conn_vld = 1'b1;
        conn     = mk(38'd0, 10'd999, 10'd999);
      end else begin
        conn_vld = 1'b0;
      end
      chk({tag, "_vld"}, 64'(out_vld), 64'd1);
      if (stalled) chk({tag, "_stable"}, 64'(out_conn), 64'(prev));
      if (out_vld && rdy) begin
        chk({tag, "_data"}, 64'(out_conn), 64'(model[0]));
        void'(model.pop_front());
        popped++;
      end
      stalled = out_vld && !rdy;
      prev    = out_conn;
      tick();
      conn_vld = 1'b0;
      cyc++;
      if (stop_after > 0 && popped == stop_after) return;
    end
    if (cyc >= 200) chk({tag, "_timeout"}, 64'(model.size()), 64'd0);
    chk({tag, "_vld_empty"}, 64'(out_vld), 64'd0);
    while (!done && w < 3) begin
      tick();
      w++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_vld_done"}, 64'(out_vld), 64'd0);
  endtask

  initial begin
    logic [63:0] r;
    logic [37:0] d;
    int w;

    // Reset state
    do_reset();
    chk("rst_vld", 64'(out_vld), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
`ifdef CONN_TOPK_DROP_CNT_EN
    chk("rst_drop", 64'(drop_cnt), 64'd0);
`endif

    // Basic sort: 50,10,30,20 -> 10,20,30,50 on consecutive cycles
    send(mk(38'd50, 10'd1, 10'd0), 1'b0);
    send(mk(38'd10, 10'd2, 10'd0), 1'b0);
    send(mk(38'd30, 10'd3, 10'd0), 1'b0);
    send(mk(38'd20, 10'd4, 10'd0), 1'b0);
    pulse_last();
    drain("sort", 0, 1'b0, 0);
    chk("sort_overrun", 64'(overrun), 64'd0);

    // Overflow: 9..4 keeps 4,5,6,7 with two discards
    do_reset();
    for (int i = 9; i >= 4; i--) send(mk(38'(i), 10'(i), 10'd7), 1'b0);
    pulse_last();
`ifdef CONN_TOPK_DROP_CNT_EN
    chk("ovf_drop", 64'(drop_cnt), 64'(drop_model));
    chk("ovf_drop2", 64'(drop_cnt), 64'd2);
`endif
    drain("ovf", 0, 1'b0, 0);

    // Ties keep arrival order
    do_reset();
    for (int i = 1; i <= 3; i++) send(mk(38'd5, 10'(i), 10'd0), 1'b0);
    pulse_last();
    drain("tie", 0, 1'b0, 0);

    // Empty stream
    do_reset();
    pulse_last();
    chk("empty_vld0", 64'(out_vld), 64'd0);
    tick();
    chk("empty_vld1", 64'(out_vld), 64'd0);
    chk("empty_done", 64'(done), 64'd1);

    // Toggling ready plus a stray conn during drain
    do_reset();
    send(mk(38'd7, 10'd1, 10'd1), 1'b0);
    send(mk(38'd3, 10'd2, 10'd2), 1'b0);
    send(mk(38'd9, 10'd3, 10'd3), 1'b0);
    send(mk(38'd1, 10'd4, 10'd4), 1'b0);
    pulse_last();
    chk("tog_overrun0", 64'(overrun), 64'd0);
    drain("tog", 1, 1'b1, 0);
    chk("tog_overrun1", 64'(overrun), 64'd1);

    // Reset mid-drain, then a fresh stream accepted right after reset
    do_reset();
    send(mk(38'd40, 10'd1, 10'd0), 1'b0);
    send(mk(38'd10, 10'd2, 10'd0), 1'b0);
    send(mk(38'd30, 10'd3, 10'd0), 1'b0);
    send(mk(38'd20, 10'd4, 10'd0), 1'b0);
    pulse_last();
    drain("pre", 0, 1'b0, 2);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_vld", 64'(out_vld), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_overrun", 64'(overrun), 64'd0);
    model.delete();
    drop_model = 0;
    rst_n = 1'b1;
    send(mk(38'd3, 10'd5, 10'd0), 1'b0);
    send(mk(38'd1, 10'd6, 10'd0), 1'b0);
    pulse_last();
    drain("post", 0, 1'b0, 0);

    // Randomized stream, wide distances, in_last with the final conn
    do_reset();
    for (int n = 0; n < 30; n++) begin
      w = $urandom_range(0, 2);
      for (int g = 0; g < w; g++) tick();
      r = {$urandom(), $urandom()};
      d = ($urandom_range(0, 3) == 0) ? r[37:0] : 38'($urandom_range(0, 15));
      send(mk(d, 10'(n), 10'($urandom_range(0, 1023))), n == 29);
    end
`ifdef CONN_TOPK_DROP_CNT_EN
    chk("rnd_drop", 64'(drop_cnt), 64'(drop_model));
`endif
    drain("rnd", 2, 1'b0, 0);

    // in_last after the stream ends changes nothing
    pulse_last();
    chk("late_last_done", 64'(done), 64'd1);
    chk("late_last_vld", 64'(out_vld), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/conn_topk.md
CONN_TOPK -- requirements
Module: conn_topk

Interface
REQ-001 SHALL have parameter K, default 1000: number of smallest-distance connections retained.
REQ-002 SHALL have parameter PTR_W, default 10: point index width, matching conn_t.pointa/pointb.
REQ-003 SHALL have parameter DIST_W, default 38: distance width, matching conn_t.distance.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port conn, input, conn_t (aoc_types_pkg): candidate connection {distance, pointa, pointb}.
REQ-007 SHALL have port conn_vld, input, 1: conn valid; no ready exists, and the block accepts one conn every cycle.
REQ-008 SHALL have port in_last, input, 1: single-cycle pulse marking end of the input stream.
REQ-009 SHALL have port out_conn, output, conn_t: current smallest retained connection.
REQ-010 SHALL have port out_vld, output, 1: out_conn valid.
REQ-011 SHALL have port out_rdy, input, 1: downstream accepts out_conn.
REQ-012 SHALL have port done, output, 1: all retained entries drained.
REQ-013 SHALL have port overrun, output, 1: sticky flag; conn_vld was seen outside COLLECT.

Function
REQ-014 SHALL hold a K-entry table ordered ascending by distance, plus an occupancy count of 0..K.
REQ-015 SHALL use three states: COLLECT, DRAIN and DONE.
REQ-016 In COLLECT, each conn_vld cycle SHALL compare conn.distance against all valid entries in parallel.
REQ-017 The new entry SHALL be inserted before the first entry with a strictly greater distance, so equal distances keep arrival order.
REQ-018 Entries at and after the insertion slot SHALL shift one position toward the tail, and the result SHALL be visible the next cycle.
REQ-019 When count<K, an insert SHALL increment count.
REQ-020 When count==K and conn.distance < entry[K-1].distance, the entry SHALL be inserted and the old tail discarded, with count unchanged.
REQ-021 When count==K and conn.distance >= entry[K-1].distance, conn SHALL be dropped and the table left unchanged.
REQ-022 Distance compares SHALL be unsigned over the full DIST_W bits.
REQ-023 On in_last in COLLECT, the state SHALL move to DRAIN next cycle. If conn_vld is asserted in the same cycle, that conn SHALL be processed first.
REQ-024 In DRAIN, out_vld SHALL equal (count>0) and out_conn SHALL equal entry[0].
REQ-025 In DRAIN, out_vld&&out_rdy SHALL shift the table one position toward the head and decrement count.
REQ-026 In DRAIN, out_conn SHALL be held stable while out_vld&&!out_rdy.
REQ-027 DRAIN with count==0 SHALL move to DONE on the next cycle; this includes an empty table at in_last.
REQ-028 DONE SHALL hold done=1 and out_vld=0 until reset.
REQ-029 conn_vld in DRAIN or DONE SHALL be ignored and SHALL set overrun.
REQ-030 in_last outside COLLECT SHALL be ignored.

Reset
REQ-031 While rst_n=0 at a clk edge, the block SHALL set: state=COLLECT, count=0, out_vld=0, done=0, overrun=0.
REQ-032 Table contents need not reset; only entries below count are ever observable.
REQ-033 A reset in any state, including mid-insert or mid-drain, SHALL discard all entries; the block accepts conn on the first cycle after rst_n=1.

Configuration
REQ-034 With macro CONN_TOPK_DROP_CNT_EN defined, the block SHALL add output drop_cnt[31:0], reset to 0.
REQ-035 drop_cnt SHALL increment on every discarded connection: a dropped conn or an evicted tail in COLLECT.
REQ-036 drop_cnt SHALL saturate at 32'hFFFFFFFF.
REQ-037 Without CONN_TOPK_DROP_CNT_EN, the drop_cnt port and its logic SHALL be absent, with all other behaviour identical.

Verification (K=4)
REQ-038 Bench SHALL drive distances 50,10,30,20 then in_last, with out_rdy=1 -> out_vld over 4 consecutive cycles carrying distances 10,20,30,50, then done=1.
REQ-039 Bench SHALL drive 6 conns with distances 9,8,7,6,5,4 then in_last -> drain yields 4,5,6,7; with the macro, drop_cnt=2.
REQ-040 Bench SHALL drive ties (distance 5, pointa 1), (5, 2), (5, 3) -> drain order pointa 1,2,3.
REQ-041 Bench SHALL assert in_last with no prior conn -> out_vld never asserts, done=1 within 2 cycles.
REQ-042 Bench SHALL toggle out_rdy 0/1 each cycle during drain -> each value appears exactly once and stays stable while stalled; a conn_vld during drain -> overrun=1 and output sequence unchanged.
REQ-043 Bench SHALL pulse rst_n=0 for 1 cycle after 2 of 4 outputs are drained -> out_vld=0, done=0, count=0; a new stream (3,1) then in_last drains 1,3.
